dcpu_wb_arbiter: RTL and testbench

Parametrised Wishbone bus arbiter placing NM CPU-side masters (instruction fetcher, load/store unit, debug/DMA) on the single external Wishbone port of the dcpu core. Each granted master keeps the bus until it drops its cycle request. Fixed-priority or round-robin selection is chosen by parameter. An optional watchdog terminates stalled transactions with an error.

---
 rtl/dcpu_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_dcpu_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_wb_arbiter.sv
// dcpu_wb_arbiter: places NM CPU-side Wishbone masters on the single external bus port.
// An owner keeps the bus until it drops cyc; an optional watchdog aborts stalled cycles with err.
//
// state | meaning
// IDLE  | no owner; arbitrate among asserted cyc requests
// OWNED | o_grant owner drives the bus until it drops cyc or the watchdog fires
module dcpu_wb_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NM-1:0]    i_m_cyc,
    input  logic [NM*SW-1:0] i_m_stb,
    input  logic [NM-1:0]    i_m_we,
    input  logic [NM*AW-1:0] i_m_addr,
    input  logic [NM*DW-1:0] i_m_dat,
    output logic [DW-1:0]    o_m_dat,
    output logic [NM-1:0]    o_m_ack,
    output logic [NM-1:0]    o_m_err,
    output logic             o_wb_cyc,
    output logic [SW-1:0]    o_wb_stb,
    output logic             o_wb_we,
    output logic [AW-1:0]    o_wb_addr,
    output logic [DW-1:0]    o_wb_dat,
    input  logic [DW-1:0]    i_wb_dat,
    input  logic             i_wb_ack,
    input  logic             i_wb_err,
    output logic [NM-1:0]    o_grant,
    output logic             o_busy
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state, state_nx;
    logic [NM-1:0]   grant_nx;
    logic [LW-1:0]   last_grant, last_nx;
    logic [LW-1:0]   hi_idx, lo_idx, win_idx;
    logic            hi_found, lo_found;
    logic [7:0]      wd_cnt, wd_nx;
    logic            wd_expire;
    logic            g_cyc, g_we;
    logic [SW-1:0]   g_stb, g_stb_act;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_dat;

    // Round-robin: lowest requester above last_grant, else wrap to lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (i_m_cyc[i]) begin
                lo_found = 1'b1;
                lo_idx   = LW'(i);
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_idx   = LW'(i);
                end
            end
        end
        win_idx = ((RR != 0) && hi_found) ? hi_idx : lo_idx;
    end

    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = '0;
        g_we   = 1'b0;
        g_addr = '0;
        g_dat  = '0;
        for (int i = 0; i < NM; i++) begin
            if (o_grant[i]) begin
                g_cyc  = i_m_cyc[i];
                g_stb  = i_m_stb[i*SW +: SW];
                g_we   = i_m_we[i];
                g_addr = i_m_addr[i*AW +: AW];
                g_dat  = i_m_dat[i*DW +: DW];
            end
        end
        g_stb_act = g_cyc ? g_stb : '0;
    end

    assign wd_expire = (TIMEOUT != 0) && (state == OWNED) && (wd_cnt == TO);

    always_comb begin
        if ((state != OWNED) || i_wb_ack || i_wb_err) begin
            wd_nx = '0;
        end else if ((|g_stb_act) && (wd_cnt != 8'hFF)) begin
            wd_nx = wd_cnt + 8'd1;
        end else begin
            wd_nx = wd_cnt;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = o_grant;
        last_nx  = last_grant;
        case (state)
            IDLE: begin
                if (lo_found) begin
                    state_nx = OWNED;
                    grant_nx = NM'(1) << win_idx;
                    last_nx  = win_idx;
                end
            end
            OWNED: begin
                if (!g_cyc || wd_expire) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            o_grant    <= '0;
            last_grant <= LW'(NM - 1);
            wd_cnt     <= '0;
        end else begin
            state      <= state_nx;
            o_grant    <= grant_nx;
            last_grant <= last_nx;
            wd_cnt     <= wd_nx;
        end
    end

    assign o_busy    = (state == OWNED);
    assign o_wb_cyc  = g_cyc && !wd_expire;
    assign o_wb_stb  = wd_expire ? '0 : g_stb_act;
    assign o_wb_we   = g_we;
    assign o_wb_addr = g_addr;
    assign o_wb_dat  = g_dat;
    assign o_m_dat   = i_wb_dat;
    // err wins over a simultaneous ack
    assign o_m_ack   = (o_busy && i_wb_ack && !i_wb_err && !wd_expire) ? o_grant : '0;
    assign o_m_err   = (o_busy && (i_wb_err || wd_expire)) ? o_grant : '0;

endmodule

// File: tb/tb_dcpu_wb_arbiter.sv
// Bench for dcpu_wb_arbiter: a fixed-priority instance driven from a vector table,
// and a round-robin instance exercised with hand-written multi-cycle sequences.
module tb_dcpu_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // fixed-priority instance: NM=2, RR=0, TIMEOUT=4
    logic        a_rst_n;
    logic [1:0]  a_m_cyc, a_m_we, a_m_ack, a_m_err, a_grant;
    logic [7:0]  a_m_stb;
    logic [63:0] a_m_addr, a_m_dat;
    logic [31:0] a_m_dat_o, a_wb_addr, a_wb_dat, a_wb_dat_in;
    logic        a_wb_cyc, a_wb_we, a_wb_ack, a_wb_err, a_busy;
    logic [3:0]  a_wb_stb;

    dcpu_wb_arbiter #(.NM(2), .AW(32), .DW(32), .SW(4), .RR(0), .TIMEOUT(4)) u_fix (
        .i_clk(clk), .i_reset_n(a_rst_n),
        .i_m_cyc(a_m_cyc), .i_m_stb(a_m_stb), .i_m_we(a_m_we),
        .i_m_addr(a_m_addr), .i_m_dat(a_m_dat),
        .o_m_dat(a_m_dat_o), .o_m_ack(a_m_ack), .o_m_err(a_m_err),
        .o_wb_cyc(a_wb_cyc), .o_wb_stb(a_wb_stb), .o_wb_we(a_wb_we),
        .o_wb_addr(a_wb_addr), .o_wb_dat(a_wb_dat),
        .i_wb_dat(a_wb_dat_in), .i_wb_ack(a_wb_ack), .i_wb_err(a_wb_err),
        .o_grant(a_grant), .o_busy(a_busy)
    );

    // round-robin instance: NM=3, RR=1, watchdog disabled
    logic        b_rst_n;
    logic [2:0]  b_m_cyc, b_m_we, b_m_ack, b_m_err, b_grant;
    logic [11:0] b_m_stb;
    logic [95:0] b_m_addr, b_m_dat;
    logic [31:0] b_m_dat_o, b_wb_addr, b_wb_dat, b_wb_dat_in;
    logic        b_wb_cyc, b_wb_we, b_wb_ack, b_wb_err, b_busy;
    logic [3:0]  b_wb_stb;

    dcpu_wb_arbiter #(.NM(3), .AW(32), .DW(32), .SW(4), .RR(1), .TIMEOUT(0)) u_rr (
        .i_clk(clk), .i_reset_n(b_rst_n),
        .i_m_cyc(b_m_cyc), .i_m_stb(b_m_stb), .i_m_we(b_m_we),
        .i_m_addr(b_m_addr), .i_m_dat(b_m_dat),
        .o_m_dat(b_m_dat_o), .o_m_ack(b_m_ack), .o_m_err(b_m_err),
        .o_wb_cyc(b_wb_cyc), .o_wb_stb(b_wb_stb), .o_wb_we(b_wb_we),
        .o_wb_addr(b_wb_addr), .o_wb_dat(b_wb_dat),
        .i_wb_dat(b_wb_dat_in), .i_wb_ack(b_wb_ack), .i_wb_err(b_wb_err),
        .o_grant(b_grant), .o_busy(b_busy)
    );

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stbon;
        logic        ack;
        logic        err;
        logic [1:0]  grant;
        logic        wbcyc;
        logic [3:0]  wbstb;
        logic [31:0] addr;
        logic [1:0]  mack;
        logic [1:0]  merr;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stbon,
                                input logic ack, input logic err,
                                input logic [1:0] grant, input logic wbcyc,
                                input logic [3:0] wbstb, input logic [31:0] addr,
                                input logic [1:0] mack, input logic [1:0] merr,
                                input logic busy);
        vec_t v;
        v.cyc = cyc; v.stbon = stbon; v.ack = ack; v.err = err;
        v.grant = grant; v.wbcyc = wbcyc; v.wbstb = wbstb; v.addr = addr;
        v.mack = mack; v.merr = merr; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] IDL = 32'h0;

    initial begin
        a_rst_n = 1'b0; a_m_cyc = 2'b11; a_m_stb = 8'h3F; a_m_we = 2'b10;
        a_m_addr = {32'h200, 32'h100}; a_m_dat = {32'h2222_2222, 32'h1111_1111};
        a_wb_dat_in = 32'hDEAD_BEEF; a_wb_ack = 1'b0; a_wb_err = 1'b0;
        b_rst_n = 1'b0; b_m_cyc = 3'b000; b_m_stb = 12'hFFF; b_m_we = 3'b000;
        b_m_addr = {32'h300, 32'h200, 32'h100}; b_m_dat = '0;
        b_wb_dat_in = '0; b_wb_ack = 1'b0; b_wb_err = 1'b0;

        // cyc stbon ack err | grant wbcyc wbstb addr mack merr busy
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 2'b01, 1, 4'hF, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 4'hF, 32'h100, 2'b01, 2'b00, 1));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 2'b01, 1, 4'hF, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 2'b01, 0, 4'h0, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 2'b10, 1, 4'h3, 32'h200, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b10, 2'b11, 1, 1, 2'b10, 1, 4'h3, 32'h200, 2'b00, 2'b10, 1));
        vecs.push_back(mk(2'b10, 2'b11, 1, 0, 2'b10, 1, 4'h3, 32'h200, 2'b10, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b11, 0, 0, 2'b10, 0, 4'h0, 32'h200, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b11, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        // request dropped during the arbitration cycle: grant still taken, then released
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        vecs.push_back(mk(2'b00, 2'b11, 0, 0, 2'b01, 0, 4'h0, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b11, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        // watchdog: stalled strobe, err on the 5th owned cycle
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(2'b01, 2'b01, 0, 0, 2'b01, 1, 4'hF, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 2'b01, 0, 4'h0, 32'h100, 2'b00, 2'b01, 1));
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 2'b01, 1, 4'hF, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b01, 0, 0, 2'b01, 0, 4'h0, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b01, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        // no strobe: watchdog must not advance
        vecs.push_back(mk(2'b01, 2'b00, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(2'b01, 2'b00, 0, 0, 2'b01, 1, 4'h0, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 4'h0, 32'h100, 2'b00, 2'b00, 1));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 4'h0, IDL,    2'b00, 2'b00, 0));

        tick(); tick();
        @(negedge clk);
        check("reset_fix", 128'({a_wb_cyc, a_wb_stb, a_wb_we, a_m_ack, a_m_err, a_grant, a_busy, a_wb_addr}), 128'(0));
        check("reset_rr",  128'({b_wb_cyc, b_wb_stb, b_wb_we, b_m_ack, b_m_err, b_grant, b_busy, b_wb_addr}), 128'(0));
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] exp_dat;
            a_m_cyc  = vecs[i].cyc;
            a_m_stb  = {vecs[i].stbon[1] ? 4'h3 : 4'h0, vecs[i].stbon[0] ? 4'hF : 4'h0};
            a_wb_ack = vecs[i].ack;
            a_wb_err = vecs[i].err;
            exp_dat  = vecs[i].grant[0] ? 32'h1111_1111 : (vecs[i].grant[1] ? 32'h2222_2222 : 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  128'({a_grant, a_wb_cyc, a_wb_stb, a_wb_addr, a_m_ack, a_m_err, a_busy,
                        a_wb_we, a_wb_dat, a_m_dat_o}),
                  128'({vecs[i].grant, vecs[i].wbcyc, vecs[i].wbstb, vecs[i].addr, vecs[i].mack,
                        vecs[i].merr, vecs[i].busy, vecs[i].grant[1], exp_dat, 32'hDEAD_BEEF}));
            tick();
        end
        a_m_cyc = 2'b00; a_wb_ack = 1'b0; a_wb_err = 1'b0;

        // round-robin: every master requests; each releases for one cycle after its ack
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp_g;
            exp_g = 3'b001 << (k % 3);
            b_m_cyc = 3'b111; b_wb_ack = 1'b0;
            tick();
            b_wb_ack = 1'b1;
            @(negedge clk);
            check($sformatf("rr_grant%0d", k), 128'({b_grant, b_wb_cyc, b_m_ack}), 128'({exp_g, 1'b1, exp_g}));
            tick();
            b_m_cyc = 3'b111 & ~exp_g; b_wb_ack = 1'b0;
            tick();
        end

        // multi-beat read by master 1
        b_m_cyc = 3'b010;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            b_wb_dat_in = 32'hA0 + 32'(k);
            b_wb_ack = 1'b1;
            @(negedge clk);
            check($sformatf("beat%0d", k), 128'({b_m_dat_o, b_m_ack, b_grant, b_wb_cyc}),
                  128'({32'hA0 + 32'(k), 3'b010, 3'b010, 1'b1}));
            tick();
        end
        b_wb_ack = 1'b0;
        b_m_cyc = 3'b000;
        @(negedge clk);
        check("beat_release", 128'({b_wb_cyc, b_busy}), 128'({1'b0, 1'b1}));
        tick();

        // TIMEOUT=0: a long stall never errors
        b_m_cyc = 3'b001;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("nowd%0d", k), 128'({b_m_err, b_wb_cyc, b_busy, b_grant}), 128'({3'b000, 1'b1, 1'b1, 3'b001}));
            tick();
        end

        // reset mid-transaction, then round-robin restarts at master 0
        b_rst_n = 1'b0;
        b_m_cyc = 3'b111;
        tick();
        b_rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid", 128'({b_wb_cyc, b_grant, b_busy, b_m_ack, b_m_err}), 128'(0));
        tick();
        @(negedge clk);
        check("rst_first", 128'({b_grant, b_wb_cyc, b_wb_addr}), 128'({3'b001, 1'b1, 32'h100}));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
